stream_demultiplexer: RTL and testbench

- Sequential counterpart of the 2:1 multiplexer: steers one input stream to one of two output streams, chosen per word by `select`.
- Each output has a 2-entry FIFO so a stalled output does not block words bound for the other output.
- Used in the FPU datapath to route operands or results to one of two consumers, e.g. the add/sub unit or the mul/div unit.

---
 rtl/stream_demultiplexer.sv | 104 ++++++++++
 tb/tb_stream_demultiplexer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demultiplexer.sv
// One input stream steered per word to one of two outputs, each behind a 2-entry FIFO.
// Optional macro DEMUX_COUNT_EN adds 16-bit per-output handshake counters.
module stream_demultiplexer #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] in_value,
  input  logic            select,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] first_value,
  output logic            first_valid,
  input  logic            first_ready,
  output logic [SIZE-1:0] second_value,
  output logic            second_valid,
`ifdef DEMUX_COUNT_EN
  output logic [15:0]     first_count,
  output logic [15:0]     second_count,
`endif
  input  logic            second_ready
);

  logic [1:0]      fifo_push;
  logic [1:0]      fifo_pop;
  logic [1:0]      fifo_full;
  logic [1:0]      fifo_valid;
  logic [1:0]      fifo_ready;
  logic [SIZE-1:0] head_value [2];

  assign fifo_ready = {second_ready, first_ready};

  // Readiness looks only at registered occupancy, so a draining full FIFO still refuses input.
  assign in_ready = ~fifo_full[select];

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [SIZE-1:0] mem_q [2];
    logic [SIZE-1:0] mem_d [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      cnt_q, cnt_d;

    assign fifo_push[gi]  = in_valid & in_ready & (select == 1'(gi));
    assign fifo_valid[gi] = (cnt_q != 2'd0);
    assign fifo_full[gi]  = (cnt_q == 2'd2);
    assign fifo_pop[gi]   = fifo_valid[gi] & fifo_ready[gi];
    assign head_value[gi] = mem_q[rd_ptr_q];

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (fifo_push[gi]) begin
        mem_d[wr_ptr_q] = in_value;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (fifo_pop[gi]) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, fifo_push[gi]} - {1'b0, fifo_pop[gi]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[0] <= '0;
        mem_q[1] <= '0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        cnt_q    <= 2'd0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

`ifdef DEMUX_COUNT_EN
    logic [15:0] hs_cnt_q, hs_cnt_d;

    // Free-running: wraps FFFF -> 0000.
    assign hs_cnt_d = hs_cnt_q + 16'(fifo_push[gi]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hs_cnt_q <= 16'd0;
      end else begin
        hs_cnt_q <= hs_cnt_d;
      end
    end
`endif
  end

  assign first_valid  = fifo_valid[0];
  assign first_value  = head_value[0];
  assign second_valid = fifo_valid[1];
  assign second_value = head_value[1];

`ifdef DEMUX_COUNT_EN
  assign first_count  = g_fifo[0].hs_cnt_q;
  assign second_count = g_fifo[1].hs_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Self-checking bench for stream_demultiplexer: directed scenarios plus randomized
// traffic compared against a queue-based model of the two output streams.
module tb_stream_demultiplexer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_value = '0;
  logic        select = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] first_value;
  logic        first_valid;
  logic        first_ready = 1'b0;
  logic [31:0] second_value;
  logic        second_valid;
  logic        second_ready = 1'b0;
`ifdef DEMUX_COUNT_EN
  logic [15:0] first_count;
  logic [15:0] second_count;
  logic [15:0] mcnt0 = '0;
  logic [15:0] mcnt1 = '0;
`endif

  int checks = 0;
  int errors = 0;

  // Model: each output is an ordered queue of at most two pending words.
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];

  stream_demultiplexer #(.SIZE(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_value     (in_value),
    .select       (select),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .first_value  (first_value),
    .first_valid  (first_valid),
    .first_ready  (first_ready),
    .second_value (second_value),
    .second_valid (second_valid),
`ifdef DEMUX_COUNT_EN
    .first_count  (first_count),
    .second_count (second_count),
`endif
    .second_ready (second_ready)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, sample in_ready, clock, and advance the model.
  task automatic tick(input logic v, input logic sel, input logic [31:0] val,
                      input logic r0, input logic r1,
                      output logic rdy_dut, output logic rdy_exp);
    logic p0, p1;
    in_valid = v; select = sel; in_value = val;
    first_ready = r0; second_ready = r1;
    #1;
    rdy_dut = in_ready;
    rdy_exp = sel ? (mq1.size() < 2) : (mq0.size() < 2);
    p0 = r0 && (mq0.size() > 0);
    p1 = r1 && (mq1.size() > 0);
    @(posedge clk);
    #1;
    if (p0) void'(mq0.pop_front());
    if (p1) void'(mq1.pop_front());
    if (v && rdy_exp) begin
      if (sel) mq1.push_back(val);
      else     mq0.push_back(val);
`ifdef DEMUX_COUNT_EN
      if (sel) mcnt1 = mcnt1 + 16'd1;
      else     mcnt0 = mcnt0 + 16'd1;
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; #1;
    checks++; if (first_valid !== 1'b0) begin errors++; $display("FAIL reset_first_valid got %b want 0", first_valid); end
    checks++; if (second_valid !== 1'b0) begin errors++; $display("FAIL reset_second_valid got %b want 0", second_valid); end
    checks++; if (first_value !== 32'h0) begin errors++; $display("FAIL reset_first_value got %h want 0", first_value); end
    checks++; if (second_value !== 32'h0) begin errors++; $display("FAIL reset_second_value got %h want 0", second_value); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_stream();
    logic rd, re;
    tick(1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, rd, re);
    checks++; if (first_value !== 32'hA5A5A5A5 || first_valid !== 1'b1) begin
      errors++; $display("FAIL mid_reset_push got %b/%h want 1/a5a5a5a5", first_valid, first_value); end
    in_valid = 1'b0;
    #2; rst_n = 1'b0; #1;
    checks++; if (first_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_async got %b want 0", first_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq0.delete(); mq1.delete();
    #1;
    checks++; if (first_valid !== 1'b0 || first_value !== 32'h0) begin
      errors++; $display("FAIL mid_reset_release got %b/%h want 0/0", first_valid, first_value); end
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rd, re);
    checks++; if (first_valid !== 1'b0 || second_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle got %b/%b want 0/0", first_valid, second_valid); end
    $display("test_reset_mid_stream done");
  endtask

  task automatic test_routing();
    logic rd, re;
    tick(1'b1, 1'b0, 32'h11, 1'b1, 1'b1, rd, re);
    checks++; if (first_valid !== 1'b1 || first_value !== 32'h11 || second_valid !== 1'b0) begin
      errors++; $display("FAIL route_first got %b/%h sv=%b want 1/00000011 sv=0", first_valid, first_value, second_valid); end
    tick(1'b1, 1'b1, 32'h22, 1'b1, 1'b1, rd, re);
    checks++; if (second_valid !== 1'b1 || second_value !== 32'h22 || first_valid !== 1'b0) begin
      errors++; $display("FAIL route_second got %b/%h fv=%b want 1/00000022 fv=0", second_valid, second_value, first_valid); end
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rd, re);
    checks++; if (first_valid !== 1'b0 || second_valid !== 1'b0) begin
      errors++; $display("FAIL route_drain got %b/%b want 0/0", first_valid, second_valid); end
    $display("test_routing done");
  endtask

  task automatic test_backpressure();
    logic rd, re;
    logic accepted;
    int   accept_cycle;
    logic [31:0] got[$];
    tick(1'b1, 1'b0, 32'd1, 1'b0, 1'b0, rd, re);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL bp_word1_ready got %b want 1", rd); end
    tick(1'b1, 1'b0, 32'd2, 1'b0, 1'b0, rd, re);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL bp_word2_ready got %b want 1", rd); end
    tick(1'b1, 1'b0, 32'd3, 1'b0, 1'b0, rd, re);
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL bp_word3_refused got %b want 0", rd); end
    accepted = 1'b0; accept_cycle = -1;
    for (int c = 0; c < 6; c++) begin
      if (first_valid) got.push_back(first_value);
      tick(!accepted, 1'b0, 32'd3, 1'b1, 1'b0, rd, re);
      if (!accepted && rd) begin accepted = 1'b1; accept_cycle = c; end
    end
    checks++; if (accept_cycle != 1) begin errors++; $display("FAIL bp_accept_cycle got %0d want 1", accept_cycle); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_out_count got %0d want 3", got.size()); end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      checks++; if (got[k] !== 32'(k + 1)) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", k, got[k], 32'(k + 1)); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_isolation();
    logic rd, re;
    tick(1'b1, 1'b0, 32'hA, 1'b0, 1'b0, rd, re);
    tick(1'b1, 1'b0, 32'hB, 1'b0, 1'b0, rd, re);
    tick(1'b1, 1'b1, 32'h0000BEEF, 1'b0, 1'b0, rd, re);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL iso_ready got %b want 1", rd); end
    checks++; if (second_valid !== 1'b1 || second_value !== 32'h0000BEEF) begin
      errors++; $display("FAIL iso_second got %b/%h want 1/0000beef", second_valid, second_value); end
    checks++; if (first_value !== 32'hA) begin errors++; $display("FAIL iso_first_head got %h want 0000000a", first_value); end
    in_valid = 1'b1; select = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL iso_first_full got %b want 0", in_ready); end
    in_valid = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rd, re);
    checks++; if (first_valid !== 1'b0 || second_valid !== 1'b0) begin
      errors++; $display("FAIL iso_drain got %b/%b want 0/0", first_valid, second_valid); end
    $display("test_isolation done");
  endtask

  task automatic test_back_to_back();
    logic rd, re;
    for (int i = 1; i <= 100; i++) begin
      tick(1'b1, 1'b1, 32'(i), 1'b0, 1'b1, rd, re);
      checks++; if (rd !== 1'b1 || second_valid !== 1'b1 || second_value !== 32'(i)) begin
        errors++; $display("FAIL b2b[%0d] got rdy=%b v=%b d=%h want 1/1/%h", i, rd, second_valid, second_value, 32'(i)); end
    end
    tick(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, rd, re);
    checks++; if (second_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", second_valid); end
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    logic rd, re;
    logic v, sel, r0, r1, pending;
    logic [31:0] val;
    pending = 1'b0; sel = 1'b0; val = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        v   = ($urandom_range(3) != 0);
        sel = 1'($urandom_range(1));
        val = $urandom;
      end
      r0 = ($urandom_range(3) != 0);
      r1 = ($urandom_range(2) != 0);
      tick(v, sel, val, r0, r1, rd, re);
      checks++; if (rd !== re) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b want %b", c, rd, re); end
      pending = v && !re;
      checks++; if (first_valid !== (mq0.size() != 0) || (mq0.size() != 0 && first_value !== mq0[0])) begin
        errors++; $display("FAIL rnd_first[%0d] got %b/%h want %b/%h", c, first_valid, first_value, mq0.size() != 0, (mq0.size() != 0) ? mq0[0] : 32'h0); end
      checks++; if (second_valid !== (mq1.size() != 0) || (mq1.size() != 0 && second_value !== mq1[0])) begin
        errors++; $display("FAIL rnd_second[%0d] got %b/%h want %b/%h", c, second_valid, second_value, mq1.size() != 0, (mq1.size() != 0) ? mq1[0] : 32'h0); end
`ifdef DEMUX_COUNT_EN
      checks++; if (first_count !== mcnt0 || second_count !== mcnt1) begin
        errors++; $display("FAIL rnd_counts[%0d] got %0d/%0d want %0d/%0d", c, first_count, second_count, mcnt0, mcnt1); end
`endif
    end
    $display("test_random done");
  endtask

`ifdef DEMUX_COUNT_EN
  task automatic test_count_wrap();
    logic rd, re;
    int n;
    n = 65536 - int'(mcnt0);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 32'(i), 1'b1, 1'b1, rd, re);
    checks++; if (first_count !== 16'h0000) begin errors++; $display("FAIL count_wrap got %h want 0000", first_count); end
    checks++; if (second_count !== mcnt1) begin errors++; $display("FAIL count_wrap_second got %h want %h", second_count, mcnt1); end
    $display("test_count_wrap done");
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_stream();
    test_routing();
    test_backpressure();
    test_isolation();
    test_back_to_back();
    test_random();
`ifdef DEMUX_COUNT_EN
    test_count_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
